sync_fifo_param: RTL and testbench

Parametrised single-clock synchronous FIFO. It is the successor to the fixed 8-bit x 1024 byte FIFO that sits between the UART receive path and the display/consumer logic. It adds configurable width and depth, a synchronous reset, programmable almost-full/almost-empty thresholds, an occupancy count output, a read-data-valid strobe and sticky overflow/underflow error flags.

---
 rtl/sync_fifo_param.sv | 136 +++++++++++++
 tb/tb_sync_fifo_param.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Single-clock synchronous FIFO with registered flags, occupancy count,
// one-cycle read latency with valid strobe, and sticky overflow/underflow errors.
module sync_fifo_param #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned AF_LEVEL = 2**ADDR_W - 4,
  parameter int unsigned AE_LEVEL = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);

  localparam int unsigned     Depth    = 2**ADDR_W;
  localparam logic [ADDR_W:0] DepthCnt = (ADDR_W+1)'(Depth);
  localparam logic [ADDR_W:0] AfCnt    = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AeCnt    = (ADDR_W+1)'(AE_LEVEL);
  localparam logic [ADDR_W:0] CntOne   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PtrOne = ADDR_W'(1);
  localparam logic              AfRst  = (AF_LEVEL == 0);

  logic [DATA_W-1:0] mem_q [Depth];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              ae_q, ae_d;
  logic              af_q, af_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              wr_ok, rd_ok;

  always_comb begin
    // A full FIFO still takes a write when the same cycle frees a slot.
    wr_ok = wr_en & (~full_q | rd_en);
    rd_ok = rd_en & ~empty_q;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;

    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end
    if (rd_ok) begin
      rd_ptr_d   = rd_ptr_q + PtrOne;
      rd_data_d  = mem_q[rd_ptr_q];
      rd_valid_d = 1'b1;
    end

    if (wr_ok && !rd_ok) begin
      count_d = count_q + CntOne;
    end else if (rd_ok && !wr_ok) begin
      count_d = count_q - CntOne;
    end

    // Flags follow the next-state count so they never lag it.
    empty_d = (count_d == '0);
    full_d  = (count_d == DepthCnt);
    ae_d    = (count_d <= AeCnt);
    af_d    = (count_d >= AfCnt);

    overflow_d  = clr_err ? 1'b0 : overflow_q;
    underflow_d = clr_err ? 1'b0 : underflow_q;
    if (wr_en && !wr_ok) begin
      overflow_d = 1'b1;
    end
    if (rd_en && !rd_ok) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      ae_q        <= 1'b1;
      af_q        <= AfRst;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      ae_q        <= ae_d;
      af_q        <= af_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset; the read above sees the pre-edge word (read-before-write).
  always_ff @(posedge clk) begin
    if (rst_n && wr_ok) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_empty = ae_q;
  assign almost_full  = af_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: directed scenarios plus randomized
// traffic, all checked against a queue-based reference model.
module tb_sync_fifo_param;

  localparam int unsigned DataW = 8;
  localparam int unsigned AddrW = 4;
  localparam int unsigned Depth = 16;
  localparam int unsigned AfLvl = 14;
  localparam int unsigned AeLvl = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             wr_en = 1'b0;
  logic [DataW-1:0] wr_data = '0;
  logic             rd_en = 1'b0;
  logic             clr_err = 1'b0;
  logic [DataW-1:0] rd_data;
  logic             rd_valid, empty, full, almost_empty, almost_full;
  logic [AddrW:0]   count;
  logic             overflow, underflow;

  sync_fifo_param #(
    .DATA_W  (DataW),
    .ADDR_W  (AddrW),
    .AF_LEVEL(AfLvl),
    .AE_LEVEL(AeLvl)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .empty       (empty),
    .full        (full),
    .almost_empty(almost_empty),
    .almost_full (almost_full),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow),
    .clr_err     (clr_err)
  );

  always #5 clk = ~clk;

  // Reference model
  logic [DataW-1:0] mq[$];
  logic [DataW-1:0] m_data = '0;
  logic             m_valid = 1'b0;
  logic             m_ovf = 1'b0;
  logic             m_unf = 1'b0;

  int n_checks = 0;
  int n_pass = 0;

  logic [11:0] st_obs;
  assign st_obs = {count, empty, full, almost_empty, almost_full, overflow, underflow, rd_valid};

  function automatic logic [11:0] exp_status();
    int n;
    n = mq.size();
    return {5'(n), n == 0, n == int'(Depth), n <= int'(AeLvl), n >= int'(AfLvl),
            m_ovf, m_unf, m_valid};
  endfunction

  // Drive one cycle of inputs, advance the model, sample 1 time unit after the edge.
  task automatic cyc(input logic we, input logic [DataW-1:0] wd, input logic re,
                     input logic ce);
    logic was_full, was_empty, wok, rok;
    wr_en = we; wr_data = wd; rd_en = re; clr_err = ce;
    was_full  = (mq.size() == int'(Depth));
    was_empty = (mq.size() == 0);
    wok = we && (!was_full || re);
    rok = re && !was_empty;
    m_valid = rok;
    if (rok) m_data = mq.pop_front();
    if (wok) mq.push_back(wd);
    if (ce) begin m_ovf = 1'b0; m_unf = 1'b0; end
    if (we && !wok) m_ovf = 1'b1;
    if (re && !rok) m_unf = 1'b1;
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
  endtask

  // Reset with busy inputs to show reset wins.
  task automatic do_reset();
    rst_n = 1'b0; wr_en = 1'b1; wr_data = 8'hEE; rd_en = 1'b1; clr_err = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    mq.delete();
    m_data = '0; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (st_obs !== exp_status()) $display("FAIL reset_status got=%h exp=%h", st_obs, exp_status());
    else n_pass++;
    n_checks++;
    if (rd_data !== 8'h00) $display("FAIL reset_rd_data got=%h exp=00", rd_data);
    else n_pass++;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, 8'(i), 1'b0, 1'b0);
      n_checks++;
      if (st_obs !== exp_status())
        $display("FAIL fill_status[%0d] got=%h exp=%h", i, st_obs, exp_status());
      else n_pass++;
      if (i == 14) begin
        n_checks++;
        if (almost_full !== 1'b1) $display("FAIL fill_af14 got=%b exp=1", almost_full);
        else n_pass++;
      end
    end
    n_checks++;
    if (full !== 1'b1 || count !== 5'd16)
      $display("FAIL fill_full got full=%b count=%0d exp full=1 count=16", full, count);
    else n_pass++;
  endtask

  task automatic test_overflow_drain();
    cyc(1'b1, 8'hAA, 1'b0, 1'b0);
    n_checks++;
    if (overflow !== 1'b1 || count !== 5'd16)
      $display("FAIL ovf_set got ovf=%b count=%0d exp ovf=1 count=16", overflow, count);
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== 8'(i + 1))
        $display("FAIL drain[%0d] got valid=%b data=%h exp valid=1 data=%h",
                 i, rd_valid, rd_data, 8'(i + 1));
      else n_pass++;
      n_checks++;
      if (st_obs !== exp_status())
        $display("FAIL drain_status[%0d] got=%h exp=%h", i, st_obs, exp_status());
      else n_pass++;
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    n_checks++;
    if (overflow !== 1'b0 || rd_valid !== 1'b0)
      $display("FAIL clr_err got ovf=%b valid=%b exp ovf=0 valid=0", overflow, rd_valid);
    else n_pass++;
  endtask

  task automatic test_underflow();
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if (st_obs !== exp_status()) $display("FAIL unf_status got=%h exp=%h", st_obs, exp_status());
    else n_pass++;
    n_checks++;
    if (underflow !== 1'b1 || rd_valid !== 1'b0 || count !== 5'd0)
      $display("FAIL unf_set got unf=%b valid=%b count=%0d exp unf=1 valid=0 count=0",
               underflow, rd_valid, count);
    else n_pass++;
    cyc(1'b1, 8'h55, 1'b1, 1'b0);
    n_checks++;
    if (count !== 5'd1 || underflow !== 1'b1 || rd_valid !== 1'b0)
      $display("FAIL empty_wr_rd got count=%0d unf=%b valid=%b exp count=1 unf=1 valid=0",
               count, underflow, rd_valid);
    else n_pass++;
  endtask

  task automatic test_full_rw();
    logic [DataW-1:0] oldest;
    while (mq.size() < int'(Depth)) cyc(1'b1, 8'($urandom), 1'b0, 1'b0);
    oldest = mq[0];
    cyc(1'b1, 8'h77, 1'b1, 1'b0);
    n_checks++;
    if (count !== 5'd16 || rd_valid !== 1'b1 || rd_data !== oldest)
      $display("FAIL full_rw got count=%0d valid=%b data=%h exp count=16 valid=1 data=%h",
               count, rd_valid, rd_data, oldest);
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== m_data)
        $display("FAIL full_drain[%0d] got data=%h exp data=%h", i, rd_data, m_data);
      else n_pass++;
    end
    n_checks++;
    if (rd_data !== 8'h77 || empty !== 1'b1)
      $display("FAIL full_last got data=%h empty=%b exp data=77 empty=1", rd_data, empty);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [DataW-1:0] pat;
    pat = 8'h30;
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin cyc(1'b1, pat, 1'b0, 1'b0); pat++; end
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(1) == 1) begin
        cyc(1'b1, pat, 1'b0, 1'b0); pat++;
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
      end else begin
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        n_checks++;
        if (rd_data !== m_data) $display("FAIL wrap_rd1[%0d] got=%h exp=%h", i, rd_data, m_data);
        else n_pass++;
        cyc(1'b1, pat, 1'b0, 1'b0); pat++;
      end
      n_checks++;
      if (st_obs !== exp_status() || rd_data !== m_data || overflow || underflow)
        $display("FAIL wrap[%0d] got st=%h data=%h exp st=%h data=%h",
                 i, st_obs, rd_data, exp_status(), m_data);
      else n_pass++;
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'($urandom), 1'b0, 1'b0);
    do_reset();
    n_checks++;
    if (count !== 5'd0 || empty !== 1'b1 || almost_empty !== 1'b1 || rd_data !== 8'h00)
      $display("FAIL mid_reset got count=%0d empty=%b ae=%b data=%h exp 0/1/1/00",
               count, empty, almost_empty, rd_data);
    else n_pass++;
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if (underflow !== 1'b1 || rd_valid !== 1'b0)
      $display("FAIL mid_reset_unf got unf=%b valid=%b exp unf=1 valid=0", underflow, rd_valid);
    else n_pass++;
  endtask

  task automatic test_random();
    int wp, rp;
    for (int i = 0; i < 600; i++) begin
      // Phases bias traffic so the run visits full and empty repeatedly.
      case ((i / 75) % 3)
        0: begin wp = 80; rp = 30; end
        1: begin wp = 25; rp = 80; end
        default: begin wp = 50; rp = 50; end
      endcase
      cyc($urandom_range(99) < wp, 8'($urandom), $urandom_range(99) < rp,
          $urandom_range(19) == 0);
      n_checks++;
      if (st_obs !== exp_status() || rd_data !== m_data)
        $display("FAIL rand[%0d] got st=%h data=%h exp st=%h data=%h",
                 i, st_obs, rd_data, exp_status(), m_data);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow_drain();
    test_underflow();
    test_full_rw();
    test_wrap();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
